// File: rtl/test_bus_ser_driver_pkg.sv
// Shared types and constants for the test_bus serial driver.
//   ser_state_e       : serialiser FSM states
//   TEST_BUS_IDLE_LVL : line level while idle / during stop bit
//   PARITY_BITS       : 1 when TEST_BUS_SER_PARITY_EN is defined, else 0
//   frame_len()       : frame length in clk cycles
package test_bus_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} ser_state_e;

  localparam logic TEST_BUS_IDLE_LVL = 1'b1;

`ifdef TEST_BUS_SER_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

  function automatic int frame_len(input int data_w, input int clks_per_bit, input int p);
    return (2 + data_w + p) * clks_per_bit;
  endfunction

endpackage

// File: rtl/test_bus_ser_driver_if.sv
// test_bus: single-wire serial test pad shared by producer and consumer.
//   master : drives test_pad
//   slave  : samples test_pad
interface test_bus;
  logic test_pad;
  modport master (output test_pad);
  modport slave  (input  test_pad);
endinterface

// File: rtl/test_bus_ser_driver_fifo.sv
// test_bus_ser_fifo: synchronous FIFO, async active-low reset flushes it.
//   push/wdata : write when !full
//   pop/rdata  : rdata shows head; pop advances when !empty
//   full/empty : status from registered pointers
module test_bus_ser_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  // One extra pointer bit distinguishes full from empty.
  logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic        do_push, do_pop;

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rptr_q[AW-1:0]];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) wptr_d = wptr_q + (AW+1)'(1);
    if (do_pop)  rptr_d = rptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage needs no reset; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/test_bus_ser_driver.sv
// test_bus_ser_driver: buffers parallel words and serialises each onto
// iface.test_pad as an idle-high frame: start(0), data LSB first,
// [even parity], stop(1). Each bit is held CLKS_PER_BIT cycles.
// Optional parity bit enabled by macro TEST_BUS_SER_PARITY_EN.
//   clk, rst_n          : clock, async active-low reset
//   in_valid/in_data    : word offer; accepted when in_ready
//   in_ready            : !fifo_full
//   iface (master)      : drives test_pad
//   busy                : frame in progress
//   frame_done          : pulse on last cycle of stop bit
module test_bus_ser_driver
  import test_bus_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  test_bus.master           iface,
  output logic              busy,
  output logic              frame_done
);
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  ser_state_e        state_q, state_d;
  logic [CNT_W-1:0]  tmr_q, tmr_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              pad_q, pad_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
`ifdef TEST_BUS_SER_PARITY_EN
  logic              par_q, par_d;
`endif

  logic              fifo_full, fifo_empty, pop;
  logic [DATA_W-1:0] fifo_rdata;
  logic              bit_end;

  assign in_ready = !fifo_full;

  test_bus_ser_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (in_valid),
    .wdata (in_data),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bit_end = (tmr_q == CNT_LAST);

  // Outputs are registered from the current state, so the pad trails the
  // state register by one cycle: pop at N+1, pad low from N+2.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    pop     = 1'b0;
    pad_d   = TEST_BUS_IDLE_LVL;
    busy_d  = (state_q != IDLE);
    done_d  = 1'b0;
`ifdef TEST_BUS_SER_PARITY_EN
    par_d   = par_q;
`endif
    if (state_q != IDLE) tmr_d = bit_end ? '0 : tmr_q + CNT_W'(1);

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_rdata;
          tmr_d   = '0;
          idx_d   = '0;
          state_d = START;
`ifdef TEST_BUS_SER_PARITY_EN
          par_d   = ^fifo_rdata;
`endif
        end
      end
      START: begin
        pad_d = 1'b0;
        if (bit_end) state_d = DATA;
      end
      DATA: begin
        pad_d = shift_q[0];
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (idx_q == IDX_LAST) begin
`ifdef TEST_BUS_SER_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
`ifdef TEST_BUS_SER_PARITY_EN
      PARITY: begin
        pad_d = par_q;
        if (bit_end) state_d = STOP;
      end
`endif
      STOP: begin
        pad_d = TEST_BUS_IDLE_LVL;
        if (bit_end) begin
          done_d = 1'b1;
          // Chain straight into the next frame with no idle gap.
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_rdata;
            idx_d   = '0;
            state_d = START;
`ifdef TEST_BUS_SER_PARITY_EN
            par_d   = ^fifo_rdata;
`endif
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      pad_q   <= TEST_BUS_IDLE_LVL;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef TEST_BUS_SER_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      pad_q   <= pad_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef TEST_BUS_SER_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign iface.test_pad = pad_q;
  assign busy           = busy_q;
  assign frame_done     = done_q;
endmodule

// File: tb/tb_test_bus_ser_driver.sv
// Scoreboard bench for test_bus_ser_driver: accepted words are queued as
// expectations; a negedge monitor rebuilds each frame from the pad and
// compares it. A second instance covers DATA_W=1, CLKS_PER_BIT=1.
module tb_test_bus_ser_driver;
  import test_bus_pkg::*;

  localparam int P     = PARITY_BITS;
  localparam int CPB   = 4;
  localparam int FLEN  = frame_len(8, CPB, P);
  localparam int NBITS = 2 + 8 + P;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready, busy, frame_done;
  logic       in_valid1;
  logic [0:0] in_data1;
  logic       in_ready1, busy1, frame_done1;

  test_bus bus0 ();
  test_bus bus1 ();

  always #5 clk = ~clk;

  test_bus_ser_driver #(.DATA_W(8), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .iface(bus0), .busy(busy), .frame_done(frame_done));

  test_bus_ser_driver #(.DATA_W(1), .CLKS_PER_BIT(1), .FIFO_DEPTH(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_data(in_data1),
    .in_ready(in_ready1), .iface(bus1), .busy(busy1), .frame_done(frame_done1));

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Expected pad level for frame bit b of word w.
  function automatic logic exp_bit(input logic [7:0] w, input int b);
    if (b == 0) return 1'b0;
    if (b <= 8) return w[b-1];
    if (P == 1 && b == 9) return ^w;
    return 1'b1;
  endfunction

  // ---------------- scoreboard monitor ----------------
  logic [7:0] exp_q[$];
  int         done_cyc[$];
  int         cyc = 0, done_cnt = 0, frames = 0, idle_err = 0;
  logic       in_fr = 1'b0;

  initial begin
    int fidx, pe, be, de;
    logic [7:0] cur;
    fidx = 0; pe = 0; be = 0; de = 0; cur = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n === 1'b1 && frame_done) done_cnt++;
      if (rst_n !== 1'b1) begin
        in_fr = 1'b0;
      end else begin
        if (!in_fr) begin
          if (bus0.test_pad == 1'b0) begin
            if (exp_q.size() == 0) begin
              chk("unexpected_frame", 1, 0);
              cur = '0;
            end else begin
              cur = exp_q.pop_front();
            end
            in_fr = 1'b1; fidx = 0; pe = 0; be = 0; de = 0;
          end else if (busy || frame_done) begin
            idle_err++;
          end
        end
        if (in_fr) begin
          if (bus0.test_pad != exp_bit(cur, fidx / CPB)) pe++;
          if (!busy) be++;
          if (frame_done != (fidx == FLEN - 1)) de++;
          fidx++;
          if (fidx == FLEN) begin
            chk($sformatf("frame_pad_%02h", cur), pe, 0);
            chk($sformatf("frame_busy_%02h", cur), be, 0);
            chk($sformatf("frame_done_%02h", cur), de, 0);
            done_cyc.push_back(cyc);
            frames++;
            in_fr = 1'b0;
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic push(input logic [7:0] d, output int waited);
    waited = 0;
    @(negedge clk);
    in_valid = 1'b1; in_data = d;
    while (!in_ready && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) chk("push_timeout", 0, 1);
    @(posedge clk);
    exp_q.push_back(d);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || in_fr) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_in_time", (n < 3000) ? 1 : 0, 1);
  endtask

  initial begin
    int w, f0, d0;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_valid1 = 1'b0; in_data1 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pad", bus0.test_pad, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // 0xA5 with latency check: accept N, pad still idle at N+1, low at N+2
    push(8'hA5, w);
    @(posedge clk); #1 chk("lat_pad_n1", bus0.test_pad, 1);
    @(posedge clk); #1 chk("lat_pad_n2", bus0.test_pad, 0);
    drain();

    // 0x07: odd number of ones, parity bit 1 when enabled
    push(8'h07, w);
    drain();

    // back-to-back frames with no idle gap
    push(8'h00, w);
    push(8'hFF, w);
    drain();
    chk("b2b_gap", done_cyc[done_cyc.size()-1] - done_cyc[done_cyc.size()-2], FLEN);

    // fill the FIFO behind a running frame; sixth word must stall
    push(8'h11, w);
    push(8'h22, w);
    push(8'h33, w);
    push(8'h44, w);
    push(8'h55, w);
    #1 chk("full_in_ready", in_ready, 0);
    push(8'h66, w);
    chk("held_word_stalled", (w > 0) ? 1 : 0, 1);
    drain();

    // reset in the middle of DATA with two words still queued
    push(8'h3C, w);
    push(8'hC1, w);
    push(8'hC2, w);
    repeat (6) @(posedge clk);
    f0 = frames; d0 = done_cnt;
    #2 rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("mid_rst_pad", bus0.test_pad, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (60) @(negedge clk);
    chk("post_rst_pad", bus0.test_pad, 1);
    chk("post_rst_frames", frames, f0);
    chk("post_rst_done", done_cnt, d0);

    // DATA_W=1, CLKS_PER_BIT=1 instance, push 1
    @(negedge clk); in_valid1 = 1'b1; in_data1 = 1'b1;
    chk("cpb1_in_ready", in_ready1, 1);
    @(posedge clk); #1 in_valid1 = 1'b0;
    @(posedge clk); #1 chk("cpb1_pad_idle", bus1.test_pad, 1);
    for (int k = 0; k < 3 + P; k++) begin
      @(posedge clk); #1;
      chk($sformatf("cpb1_pad_%0d", k), bus1.test_pad, (k == 0) ? 0 : 1);
      chk($sformatf("cpb1_done_%0d", k), frame_done1, (k == 2 + P) ? 1 : 0);
      chk($sformatf("cpb1_busy_%0d", k), busy1, 1);
    end
    @(posedge clk); #1;
    chk("cpb1_end_busy", busy1, 0);
    chk("cpb1_end_done", frame_done1, 0);

    chk("idle_busy_or_done", idle_err, 0);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end
endmodule
